// File: rtl/mini_alu_pkg.sv
// Shared types and constants for the divider issue stage.
package mini_alu_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] DZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mini_alu_req_fifo.sv
// Request buffer: synchronous FIFO with registered full/empty flags so that
// in_ready never depends combinationally on the consumer side.
module mini_alu_req_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mini_alu_div_issue.sv
// Issue/sequencing stage in front of the 16-bit restoring divider: buffers
// requests, starts the divider one request at a time and returns tagged results.
module mini_alu_div_issue
    import mini_alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [15:0]      div_x,
    output logic [15:0]      div_y,
    input  logic [15:0]      div_quot,
    input  logic [15:0]      div_rem,
    input  logic             div_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_quot,
    output logic [15:0]      out_rem,
    output logic             out_dz,
    output logic             out_timeout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int REQ_W = 2 * DATA_W + TAG_W;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [REQ_W-1:0]   head;
    logic [15:0]        head_x;
    logic [15:0]        head_y;
    logic [TAG_W-1:0]   head_tag;
    logic               head_dz;
    logic [CNT_W-1:0]   wait_cnt;
    logic               done;
    logic               hung;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    assign pop      = (state == IDLE) & ~fifo_empty;
    assign {head_x, head_y, head_tag} = head;
    assign head_dz  = (head_y == '0);
    assign done     = (state == WAIT) & div_valid;
    assign hung     = (state == WAIT) & ~div_valid & (wait_cnt == CNT_LAST);

    mini_alu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_x, in_y, in_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = head_dz ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (done || hung) state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_start = (state == ISSUE);
        out_valid = (state == RESP);
        busy      = (state != IDLE) | ~fifo_empty;
    end

    // Operands stay in div_x/div_y from pop until the result is captured;
    // divide-by-zero results are formed at pop time and skip the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_x       <= '0;
            div_y       <= '0;
            out_tag     <= '0;
            out_quot    <= '0;
            out_rem     <= '0;
            out_dz      <= 1'b0;
            out_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (pop) begin
                div_x       <= head_x;
                div_y       <= head_y;
                out_tag     <= head_tag;
                out_quot    <= head_dz ? DZ_QUOT : '0;
                out_rem     <= head_dz ? head_x : '0;
                out_dz      <= head_dz;
                out_timeout <= 1'b0;
            end
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (done) begin
                out_quot    <= div_quot;
                out_rem     <= div_rem;
                out_dz      <= 1'b0;
                out_timeout <= 1'b0;
            end else if (hung) begin
                out_quot    <= '0;
                out_rem     <= '0;
                out_dz      <= 1'b0;
                out_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mini_alu_div_issue.sv
// Directed bench for mini_alu_div_issue with a behavioural 16-cycle divider.
module tb_mini_alu_div_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [3:0]  in_tag = '0;
    logic        div_start;
    logic [15:0] div_x;
    logic [15:0] div_y;
    logic [15:0] div_quot;
    logic [15:0] div_rem;
    logic        div_valid;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_quot;
    logic [15:0] out_rem;
    logic        out_dz;
    logic        out_timeout;
    logic [3:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_pass = 0;

    // Divider model: result pulse 17 cycles after the start pulse.
    logic [15:0] m_x;
    logic [15:0] m_y;
    int          m_cnt;
    logic        m_valid;
    logic        hang = 1'b0;
    logic        stray = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_x <= '0; m_y <= '0; m_cnt <= 0; m_valid <= 1'b0;
        end else if (div_start) begin
            m_x <= div_x; m_y <= div_y; m_cnt <= 16; m_valid <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt   <= m_cnt - 1;
            m_valid <= (m_cnt == 1) && !hang;
        end else begin
            m_valid <= 1'b0;
        end
    end

    assign div_valid = m_valid | stray;
    assign div_quot  = (m_y != 16'd0) ? m_x / m_y : 16'd0;
    assign div_rem   = (m_y != 16'd0) ? m_x % m_y : 16'd0;

    mini_alu_div_issue #(
        .FIFO_DEPTH  (2),
        .TAG_W       (4),
        .TIMEOUT_CYC (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_tag      (in_tag),
        .div_start   (div_start),
        .div_x       (div_x),
        .div_y       (div_y),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .div_valid   (div_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_dz      (out_dz),
        .out_timeout (out_timeout),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag, output bit ok);
        in_x = x; in_y = y; in_tag = tag; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int n, output bit ok);
        n = 0;
        while (!out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if ({in_ready, out_valid, busy, div_start} !== 4'b1000) $display("FAIL reset_ctrl got %b want 1000", {in_ready, out_valid, busy, div_start}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({div_x, div_y} !== 32'd0) $display("FAIL reset_div_xy got %h want 0", {div_x, div_y}); else n_pass++;
        n_checks++; if ({out_quot, out_rem, out_dz, out_timeout, out_tag} !== 38'd0) $display("FAIL reset_out got %h want 0", {out_quot, out_rem, out_dz, out_timeout, out_tag}); else n_pass++;
        n_checks++; if ({in_ready, out_valid, busy, div_start} !== 4'b1000) $display("FAIL reset_release got %b want 1000", {in_ready, out_valid, busy, div_start}); else n_pass++;
    endtask

    task automatic test_single;
        bit ok; int starts = 0; int start_k = -1; int out_k = -1;
        logic [15:0] q = '0, r = '0; logic [3:0] t = '0; logic dz = 1'b1, to = 1'b1;
        out_ready = 1'b1;
        send(16'd100, 16'd7, 4'd3, ok);
        n_checks++; if (!ok) $display("FAIL single_accept got 0 want 1"); else n_pass++;
        for (int k = 1; k <= 25; k++) begin
            if (div_start) begin starts++; start_k = k; end
            if (out_valid && out_k < 0) begin
                out_k = k; q = out_quot; r = out_rem; t = out_tag; dz = out_dz; to = out_timeout;
            end
            @(negedge clk);
        end
        n_checks++; if (starts != 1 || start_k != 2) $display("FAIL single_start got %0d pulses at %0d want 1 at 2", starts, start_k); else n_pass++;
        n_checks++; if (out_k != 20) $display("FAIL single_latency got %0d want 20", out_k); else n_pass++;
        n_checks++; if (q !== 16'd14 || r !== 16'd2) $display("FAIL single_result got %0d/%0d want 14/2", q, r); else n_pass++;
        n_checks++; if (t !== 4'd3 || dz !== 1'b0 || to !== 1'b0) $display("FAIL single_flags got tag=%0d dz=%b to=%b want 3 0 0", t, dz, to); else n_pass++;
    endtask

    task automatic test_div_zero;
        bit ok; int starts = 0; int out_k = -1;
        logic [15:0] q = '0, r = '0; logic [3:0] t = '0; logic dz = 1'b0;
        send(16'd1234, 16'd0, 4'd5, ok);
        for (int k = 1; k <= 8; k++) begin
            if (div_start) starts++;
            if (out_valid && out_k < 0) begin out_k = k; q = out_quot; r = out_rem; t = out_tag; dz = out_dz; end
            @(negedge clk);
        end
        n_checks++; if (out_k != 2) $display("FAIL dz_latency got %0d want 2", out_k); else n_pass++;
        n_checks++; if (q !== 16'hFFFF || r !== 16'd1234) $display("FAIL dz_result got %h/%0d want ffff/1234", q, r); else n_pass++;
        n_checks++; if (dz !== 1'b1 || t !== 4'd5) $display("FAIL dz_flags got dz=%b tag=%0d want 1 5", dz, t); else n_pass++;
        n_checks++; if (starts != 0) $display("FAIL dz_no_start got %0d want 0", starts); else n_pass++;
    endtask

    logic [15:0] bx [3] = '{16'd65535, 16'd9, 16'd500};
    logic [15:0] by [3] = '{16'd1, 16'd10, 16'd25};
    logic [15:0] eq [3] = '{16'd65535, 16'd0, 16'd20};
    logic [15:0] er [3] = '{16'd0, 16'd9, 16'd0};

    task automatic test_back_to_back;
        int idx = 0; int acc3 = -1; int nres = 0; bit fire = 0;
        logic ir3 = 1'b1, ir21 = 1'b1, ir22 = 1'b0;
        logic [15:0] rq [3]; logic [15:0] rr [3]; logic [3:0] rt [3];
        for (int k = 0; k < 75; k++) begin
            if (fire) begin idx++; if (idx == 3) acc3 = k - 1; end
            if (k == 3)  ir3 = in_ready;
            if (k == 21) ir21 = in_ready;
            if (k == 22) ir22 = in_ready;
            if (out_valid && out_ready && nres < 3) begin
                rq[nres] = out_quot; rr[nres] = out_rem; rt[nres] = out_tag; nres++;
            end
            if (idx < 3) begin
                in_valid = 1'b1; in_x = bx[idx]; in_y = by[idx]; in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            fire = in_valid && in_ready;
            @(negedge clk);
        end
        n_checks++; if (acc3 != 2) $display("FAIL b2b_third_accept got %0d want 2", acc3); else n_pass++;
        n_checks++; if (ir3 !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", ir3); else n_pass++;
        n_checks++; if ({ir21, ir22} !== 2'b01) $display("FAIL b2b_ready_registered got %b want 01", {ir21, ir22}); else n_pass++;
        n_checks++; if (nres != 3) $display("FAIL b2b_count got %0d want 3", nres); else n_pass++;
        for (int i = 0; i < nres; i++) begin
            n_checks++;
            if (rq[i] !== eq[i] || rr[i] !== er[i] || rt[i] !== 4'(i))
                $display("FAIL b2b_result%0d got %0d/%0d tag %0d want %0d/%0d tag %0d", i, rq[i], rr[i], rt[i], eq[i], er[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_stall;
        bit ok, ok2; int n; int start_r = -1; bit stable = 1; bit started = 0;
        logic [15:0] sq, sr; logic [3:0] st;
        out_ready = 1'b0;
        send(16'd50, 16'd5, 4'd7, ok);
        send(16'd7, 16'd2, 4'd8, ok2);
        n_checks++; if (!(ok && ok2)) $display("FAIL stall_accept got %b%b want 11", ok, ok2); else n_pass++;
        wait_out(40, n, ok);
        n_checks++; if (!ok) $display("FAIL stall_first_valid got 0 want 1"); else n_pass++;
        sq = out_quot; sr = out_rem; st = out_tag;
        n_checks++; if (sq !== 16'd10 || sr !== 16'd0 || st !== 4'd7) $display("FAIL stall_first_result got %0d/%0d tag %0d want 10/0 tag 7", sq, sr, st); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (div_start) started = 1;
            if (!out_valid || out_quot !== sq || out_rem !== sr || out_tag !== st) stable = 0;
        end
        n_checks++; if (!stable) $display("FAIL stall_stable got 0 want 1"); else n_pass++;
        n_checks++; if (started) $display("FAIL stall_no_start got 1 want 0"); else n_pass++;
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if (div_start && start_r < 0) start_r = r;
            @(negedge clk);
        end
        n_checks++; if (start_r != 2) $display("FAIL stall_release_issue got %0d want 2", start_r); else n_pass++;
        wait_out(30, n, ok);
        n_checks++; if (!ok || out_quot !== 16'd3 || out_rem !== 16'd1 || out_tag !== 4'd8) $display("FAIL stall_second_result got %0d/%0d tag %0d want 3/1 tag 8", out_quot, out_rem, out_tag); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok; int n; int out_k = -1;
        logic [15:0] q = 16'hDEAD, r = 16'hDEAD; logic to = 1'b0, dz = 1'b1; logic [3:0] t = '0;
        hang = 1'b1;
        send(16'd10, 16'd3, 4'd9, ok);
        for (int k = 1; k <= 35; k++) begin
            if (out_valid && out_k < 0) begin out_k = k; q = out_quot; r = out_rem; to = out_timeout; dz = out_dz; t = out_tag; end
            @(negedge clk);
        end
        n_checks++; if (out_k != 27) $display("FAIL timeout_latency got %0d want 27", out_k); else n_pass++;
        n_checks++; if (q !== 16'd0 || r !== 16'd0) $display("FAIL timeout_result got %0d/%0d want 0/0", q, r); else n_pass++;
        n_checks++; if (to !== 1'b1 || dz !== 1'b0 || t !== 4'd9) $display("FAIL timeout_flags got to=%b dz=%b tag=%0d want 1 0 9", to, dz, t); else n_pass++;
        hang = 1'b0;
        send(16'd21, 16'd4, 4'd10, ok);
        wait_out(30, n, ok);
        n_checks++; if (!ok || out_quot !== 16'd5 || out_rem !== 16'd1 || out_timeout !== 1'b0) $display("FAIL timeout_recover got %0d/%0d to=%b want 5/1 to=0", out_quot, out_rem, out_timeout); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2, ok3; bit quiet = 1;
        send(16'd1000, 16'd3, 4'd1, ok1);
        send(16'd2000, 16'd7, 4'd2, ok2);
        send(16'd3000, 16'd9, 4'd3, ok3);
        repeat (4) @(negedge clk);
        n_checks++; if (!(ok1 && ok2 && ok3) || in_ready !== 1'b0 || div_x !== 16'd1000) $display("FAIL rstmid_setup got ready=%b div_x=%0d want 0 1000", in_ready, div_x); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({in_ready, out_valid, busy, div_start} !== 4'b1000) $display("FAIL rstmid_ctrl got %b want 1000", {in_ready, out_valid, busy, div_start}); else n_pass++;
        n_checks++; if ({div_x, div_y, out_quot, out_rem, out_tag} !== 68'd0) $display("FAIL rstmid_data got %h want 0", {div_x, div_y, out_quot, out_rem, out_tag}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy || out_valid || div_start) quiet = 0;
            @(negedge clk);
        end
        n_checks++; if (!quiet) $display("FAIL rstmid_stray got activity want none"); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_div_zero();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
